meas_sequencer: RTL and testbench

//  Parametrised multi-channel dual-slope conversion sequencer for the voltmeter digital core.
//  - Scans an enabled set of AFE channels and, for each channel, runs settle -> auto-zero -> integrate -> de-integrate.
//  - Stores a signed result per channel in a readable bank and raises a sticky interrupt at end of scan.
//  - Sits between the sync_and_filter outputs and the SPI register layer.

---
 rtl/meas_pkg.sv | 35 +++
 rtl/meas_sequencer_if.sv | 23 ++
 rtl/meas_timer.sv | 25 ++
 rtl/meas_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_meas_sequencer.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/meas_pkg.sv
// rtl/meas_pkg.sv - shared FSM encoding, result-word field offsets and helpers for meas_sequencer
package meas_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_WAIT_RDY,
        ST_AUTOZERO,
        ST_INTEGRATE,
        ST_DEINT,
        ST_STORE,
        ST_NEXT
    } meas_state_e;

    localparam int CNT_LSB = 0;

    function automatic int sign_bit(input int cnt_w);
        return cnt_w;
    endfunction

    function automatic int err_bit(input int cnt_w);
        return cnt_w + 1;
    endfunction

    function automatic int vld_bit(input int cnt_w);
        return cnt_w + 2;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/meas_sequencer_if.sv
// rtl/meas_sequencer_if.sv - AFE control and comparator bundle between sequencer (master) and front end
interface meas_sequencer_if #(
    parameter int NUM_CH = 4
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [CH_W-1:0] afe_sel_o;
    logic            mode_sel_o;
    logic            ref_sign_o;
    logic            afe_reset_o;
    logic            comp_i;
    logic            analog_ready_i;

    modport master (
        output afe_sel_o, mode_sel_o, ref_sign_o, afe_reset_o,
        input  comp_i, analog_ready_i
    );

    modport slave (
        input  afe_sel_o, mode_sel_o, ref_sign_o, afe_reset_o,
        output comp_i, analog_ready_i
    );
endinterface

// File: rtl/meas_timer.sv
// rtl/meas_timer.sv - loadable down-counter with zero flag for settle/auto-zero/integrate intervals
module meas_timer #(
    parameter int W = 10
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_zero
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/meas_sequencer.sv
// rtl/meas_sequencer.sv - multi-channel dual-slope conversion sequencer with result bank and irq
// Optional MEAS_AVG_EN: average 2**AVG_LOG2 conversions per channel.
module meas_sequencer
    import meas_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 16,
    parameter int T_SETTLE    = 16,
    parameter int T_AZ        = 256,
    parameter int T_INT       = 1000,
    parameter int T_DEINT_MAX = 2000,
    parameter int AVG_LOG2    = 2,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              continuous_i,
    input  logic [NUM_CH-1:0] chan_mask_i,
    input  logic              irq_ack_i,
    input  logic [CH_W-1:0]   rd_addr_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              irq_o,
    output logic              range_error_o,
    output logic [CNT_W+2:0]  rd_data_o,
    meas_sequencer_if.master  afe
);
`ifdef MEAS_AVG_EN
    localparam int AVG_SH = AVG_LOG2;
`else
    localparam int AVG_SH = AVG_LOG2 * 0;
`endif
    localparam int ACC_W    = CNT_W + AVG_SH;
    localparam int CONV_W   = (AVG_SH > 0) ? AVG_SH : 1;
    localparam int AVG_N    = 1 << AVG_SH;
    localparam int RD_W     = CNT_W + 3;
    localparam int VLD_BIT  = vld_bit(CNT_W);
    localparam int TMR_W    = $clog2(max3(T_SETTLE, T_AZ, T_INT) + 1);

    meas_state_e       r_state, w_next;
    logic [NUM_CH-1:0] r_mask;
    logic [CH_W-1:0]   r_ch, w_first_ch, w_next_ch;
    logic              w_has_first, w_has_next;
    logic              r_busy, r_done, r_irq, r_rerr, r_pol, r_err;
    logic [CNT_W-1:0]  r_dcnt, w_conv_cnt, w_store_cnt;
    logic              w_flip, w_timeout, w_conv_err, w_deint_done, w_last_conv;
    logic [ACC_W-1:0]  r_acc;
    logic [CONV_W-1:0] r_conv;
    logic [RD_W-1:0]   r_bank [NUM_CH];
    logic [RD_W-1:0]   r_rd;
    logic              w_tmr_load, w_tmr_en, w_tmr_zero;
    logic [TMR_W-1:0]  w_tmr_val;
    logic              w_scan_start, w_scan_end;

    meas_timer #(.W(TMR_W)) u_timer (
        .i_clk      (clk_i),
        .i_rst      (rst_i),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_en       (w_tmr_en),
        .o_zero     (w_tmr_zero)
    );

    // Descending scan leaves the lowest matching index in the result.
    always_comb begin
        w_first_ch  = '0;
        w_has_first = 1'b0;
        w_next_ch   = '0;
        w_has_next  = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (chan_mask_i[i]) begin
                w_first_ch  = CH_W'(i);
                w_has_first = 1'b1;
            end
            if (r_mask[i] && i > int'(r_ch)) begin
                w_next_ch  = CH_W'(i);
                w_has_next = 1'b1;
            end
        end
    end

    assign w_flip       = (afe.comp_i != r_pol);
    assign w_timeout    = (r_dcnt == CNT_W'(T_DEINT_MAX - 1));
    assign w_deint_done = (r_state == ST_DEINT) && (w_flip || w_timeout);
    assign w_conv_err   = !w_flip && w_timeout;
    assign w_conv_cnt   = w_flip ? r_dcnt : '1;
    assign w_last_conv  = (r_conv == CONV_W'(AVG_N - 1));
    assign w_store_cnt  = r_err ? '1 : r_acc[ACC_W-1:AVG_SH];

    assign w_scan_end   = (r_state == ST_NEXT) && !w_has_next;
    assign w_scan_start = ((r_state == ST_IDLE) && start_i && w_has_first) ||
                          (w_scan_end && continuous_i && w_has_first);

    always_comb begin
        w_next     = r_state;
        w_tmr_en   = 1'b0;
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        case (r_state)
            ST_IDLE:      if (start_i && w_has_first) w_next = ST_SETTLE;
            ST_SETTLE:    if (w_tmr_zero) w_next = ST_WAIT_RDY; else w_tmr_en = 1'b1;
            ST_WAIT_RDY:  if (afe.analog_ready_i) w_next = ST_AUTOZERO;
            ST_AUTOZERO:  if (w_tmr_zero) w_next = ST_INTEGRATE; else w_tmr_en = 1'b1;
            ST_INTEGRATE: if (w_tmr_zero) w_next = ST_DEINT; else w_tmr_en = 1'b1;
            ST_DEINT:     if (w_deint_done) w_next = w_last_conv ? ST_STORE : ST_AUTOZERO;
            ST_STORE:     w_next = ST_NEXT;
            ST_NEXT:      w_next = (w_has_next || (continuous_i && w_has_first)) ? ST_SETTLE : ST_IDLE;
            default:      w_next = ST_IDLE;
        endcase
        if (w_next != r_state) begin
            case (w_next)
                ST_SETTLE:    begin w_tmr_load = 1'b1; w_tmr_val = TMR_W'(T_SETTLE - 1); end
                ST_AUTOZERO:  begin w_tmr_load = 1'b1; w_tmr_val = TMR_W'(T_AZ - 1);     end
                ST_INTEGRATE: begin w_tmr_load = 1'b1; w_tmr_val = TMR_W'(T_INT - 1);    end
                default:      ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mask <= '0;
            r_ch   <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_irq  <= 1'b0;
            r_rerr <= 1'b0;
            r_pol  <= 1'b0;
            r_err  <= 1'b0;
            r_dcnt <= '0;
            r_acc  <= '0;
            r_conv <= '0;
            r_rd   <= '0;
            for (int i = 0; i < NUM_CH; i++) r_bank[i] <= '0;
        end else begin
            r_done <= w_scan_end;
            // An ack landing in the done_o cycle must not swallow the new interrupt.
            if (w_scan_end)                  r_irq <= 1'b1;
            else if (irq_ack_i && !r_done)   r_irq <= 1'b0;

            if (w_scan_start) begin
                r_mask <= chan_mask_i;
                r_ch   <= w_first_ch;
                r_busy <= 1'b1;
                r_rerr <= 1'b0;
                for (int i = 0; i < NUM_CH; i++)
                    if (chan_mask_i[i]) r_bank[i][VLD_BIT] <= 1'b0;
            end else if (w_scan_end) begin
                r_busy <= 1'b0;
            end else if (r_state == ST_NEXT) begin
                r_ch <= w_next_ch;
            end

            case (r_state)
                ST_SETTLE: begin
                    r_acc  <= '0;
                    r_err  <= 1'b0;
                    r_conv <= '0;
                end
                ST_INTEGRATE: begin
                    r_dcnt <= '0;
                    if (w_tmr_zero) r_pol <= afe.comp_i;
                end
                ST_DEINT: begin
                    if (w_deint_done) begin
                        r_acc  <= r_acc + ACC_W'(w_conv_cnt);
                        r_err  <= r_err | w_conv_err;
                        r_conv <= r_conv + 1'b1;
                        r_dcnt <= '0;
                    end else begin
                        r_dcnt <= r_dcnt + 1'b1;
                    end
                end
                ST_STORE: begin
                    r_bank[r_ch] <= {1'b1, r_err, r_pol, w_store_cnt};
                    if (r_err) r_rerr <= 1'b1;
                end
                default: ;
            endcase

            r_rd <= (int'(rd_addr_i) < NUM_CH) ? r_bank[rd_addr_i] : '0;
        end
    end

    assign busy_o          = r_busy;
    assign done_o          = r_done;
    assign irq_o           = r_irq;
    assign range_error_o   = r_rerr;
    assign rd_data_o       = r_rd;
    assign afe.afe_sel_o   = r_ch;
    assign afe.mode_sel_o  = (r_state == ST_DEINT);
    assign afe.ref_sign_o  = r_pol;
    assign afe.afe_reset_o = (r_state == ST_AUTOZERO);
endmodule

// File: tb/tb_meas_sequencer.sv
// tb/tb_meas_sequencer.sv - directed self-checking bench for meas_sequencer
module tb_meas_sequencer;
`ifdef MEAS_AVG_EN
    localparam int CONV_N  = 4;
    localparam int AVG_EXP = 101;
`else
    localparam int CONV_N  = 1;
    localparam int AVG_EXP = 100;
`endif

    logic        clk;
    logic        rst, start, cont, irq_ack;
    logic [3:0]  mask;
    logic [1:0]  rd_addr;
    logic        busy, done, irq, rerr;
    logic [18:0] rd_data;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;
    int flip_at = -1;
    bit step    = 1'b0;
    int conv_idx, last_len, dcnt;
    bit in_deint;
    int sel_q[$];

    meas_sequencer_if #(.NUM_CH(4)) afe_if ();

    meas_sequencer dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .continuous_i  (cont),
        .chan_mask_i   (mask),
        .irq_ack_i     (irq_ack),
        .rd_addr_i     (rd_addr),
        .busy_o        (busy),
        .done_o        (done),
        .irq_o         (irq),
        .range_error_o (rerr),
        .rd_data_o     (rd_data),
        .afe           (afe_if.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [18:0] word(input bit v, input bit e, input bit s, input logic [15:0] c);
        return {v, e, s, c};
    endfunction

    // Comparator model: holds pol (=1) and flips flip_at cycles into each de-integrate.
    initial begin
        afe_if.comp_i         = 1'b1;
        afe_if.analog_ready_i = 1'b1;
        dcnt = 0; in_deint = 0; conv_idx = 0; last_len = 0;
        forever begin
            @(negedge clk);
            if (afe_if.mode_sel_o) begin
                if (dcnt == 0) sel_q.push_back(int'(afe_if.afe_sel_o));
                afe_if.comp_i = (flip_at >= 0 && dcnt == flip_at + (step ? conv_idx % 4 : 0)) ? 1'b0 : 1'b1;
                dcnt++;
                in_deint = 1'b1;
            end else begin
                if (in_deint) begin
                    last_len = dcnt;
                    conv_idx++;
                end
                in_deint = 1'b0;
                dcnt = 0;
                afe_if.comp_i = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (done) n_done++;
        end
    end

    task automatic start_scan(input logic [3:0] m);
        @(negedge clk);
        mask  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", done, 1);
    endtask

    task automatic read_bank(input logic [1:0] a, output logic [18:0] d);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        d = rd_data;
    endtask

    initial begin
        logic [18:0] d;
        int k, nd;
        rst = 1'b1; start = 1'b0; cont = 1'b0; mask = '0; irq_ack = 1'b0; rd_addr = '0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {busy, done, irq, rerr}, 0);
        check("rst_afe", {afe_if.afe_sel_o, afe_if.mode_sel_o, afe_if.ref_sign_o, afe_if.afe_reset_o}, 0);
        check("rst_rd", rd_data, 0);
        rst = 1'b0;

        // Two-channel scan, flip at 500
        sel_q.delete(); flip_at = 500; step = 1'b0;
        start_scan(4'b0101);
        check("t1_busy", busy, 1);
        wait_done(40000);
        @(negedge clk);
        check("t1_ndone", n_done, 1);
        check("t1_irq", irq, 1);
        check("t1_busy_end", busy, 0);
        check("t1_rerr", rerr, 0);
        check("t1_nsel", sel_q.size(), 2 * CONV_N);
        check("t1_sel_first", sel_q[0], 0);
        check("t1_sel_last", sel_q[sel_q.size() - 1], 2);
        read_bank(2'd0, d); check("t1_bank0", d, word(1, 0, 1, 16'd500));
        read_bank(2'd1, d); check("t1_bank1", d, 0);
        read_bank(2'd2, d); check("t1_bank2", d, word(1, 0, 1, 16'd500));

        // No flip: timeout and range error
        flip_at = -1;
        start_scan(4'b0010);
        wait_done(80000);
        @(negedge clk);
        check("t2_deint_len", last_len, 2000);
        check("t2_rerr", rerr, 1);
        read_bank(2'd1, d); check("t2_bank1", d, word(1, 1, 1, 16'hFFFF));

        // Ignored starts: mask 0 while idle, any start while busy
        nd = n_done;
        start_scan(4'b0000);
        repeat (20) @(negedge clk);
        check("t3_mask0_busy", busy, 0);
        flip_at = 500;
        start_scan(4'b0001);
        repeat (50) @(negedge clk);
        start_scan(4'b1111);
        check("t3_busy_hold", {busy, afe_if.afe_sel_o}, 3'b100);
        wait_done(40000);
        repeat (50) @(negedge clk);
        check("t3_ndone", n_done, nd + 2 - 1);
        check("t3_rerr_clr", rerr, 0);
        read_bank(2'd3, d); check("t3_bank3", d, 0);
        read_bank(2'd1, d); check("t3_bank1_kept", d, word(1, 1, 1, 16'hFFFF));

        // irq ack coincident with done, then a later ack
        irq_ack = 1'b1; @(negedge clk); irq_ack = 1'b0;
        check("t5_pre_ack", irq, 0);
        start_scan(4'b0001);
        wait_done(40000);
        irq_ack = 1'b1; @(negedge clk); irq_ack = 1'b0;
        check("t5_ack_coinc", irq, 1);
        @(negedge clk); irq_ack = 1'b1; @(negedge clk); irq_ack = 1'b0;
        check("t5_ack_later", irq, 0);

        // Reset during INTEGRATE
        start_scan(4'b0100);
        k = 0;
        while (!afe_if.afe_reset_o && k < 2000) begin @(negedge clk); k++; end
        check("t4_az_seen", afe_if.afe_reset_o, 1);
        k = 0;
        while (afe_if.afe_reset_o && k < 1000) begin @(negedge clk); k++; end
        repeat (10) @(negedge clk);
        nd = n_done;
        rst = 1'b1;
        @(negedge clk);
        check("t4_rst_ctrl", {busy, done, irq, rerr}, 0);
        check("t4_rst_afe", {afe_if.afe_sel_o, afe_if.mode_sel_o, afe_if.ref_sign_o, afe_if.afe_reset_o}, 0);
        check("t4_rst_rd", rd_data, 0);
        rst = 1'b0;
        for (int a = 0; a < 4; a++) begin
            read_bank(2'(a), d);
            check("t4_bank_clr", d, 0);
        end
        check("t4_no_done", n_done, nd);
        flip_at = 300;
        start_scan(4'b1000);
        wait_done(40000);
        read_bank(2'd3, d); check("t4_bank3", d, word(1, 0, 1, 16'd300));

        // Averaging: counts 100/101/102/103
        flip_at = 100; step = 1'b1; conv_idx = 0;
        start_scan(4'b0001);
        wait_done(40000);
        read_bank(2'd0, d); check("t6_avg", d, word(1, 0, 1, 16'(AVG_EXP)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
